// File: rtl/memu_if.sv
// Memory-port and loader bundle between memu and its masters (dispatchu core side and byte loader).
interface memu_if;
    logic [31:0] addr;
    logic [15:0] memOut;
    logic        memWrite;
    logic [15:0] memDat;
    logic        ldValid;
    logic [7:0]  ldByte;
    logic        ldLast;
    logic        ldReady;

    modport master (
        output addr, memOut, memWrite, ldValid, ldByte, ldLast,
        input  memDat, ldReady
    );

    modport slave (
        input  addr, memOut, memWrite, ldValid, ldByte, ldLast,
        output memDat, ldReady
    );
endinterface

// File: rtl/memu.sv
// Word-addressed RAM responder with a big-endian byte loader that holds the core off until the image is in.
// Optional MEMU_OOR_TRAP_EN: flag and block RUN accesses with nonzero address bits above ADDR_BITS.
//
// state   | meaning
// LOAD_HI | waiting for the high byte of the next image word
// LOAD_LO | high byte held, waiting for the low byte
// RUN     | image loaded, core owns the memory port until reset
module memu #(
    parameter int ADDR_BITS = 8
) (
    input  logic               clk,
    input  logic               rstN,
    memu_if.slave              bus,
    output logic               cpuRun,
    output logic [ADDR_BITS:0] loadCount,
    output logic               fault
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] LAST_IDX = (ADDR_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

    state_t               state_q, state_d;
    logic [7:0]           hi_q, hi_d;
    logic [ADDR_BITS:0]   load_count_q, load_count_d;
    logic [ADDR_BITS-1:0] sel_q, sel_d;
    logic                 oor_sel_q, oor_sel_d;
    logic                 fault_q, fault_d;

    logic [15:0]          mem [DEPTH];
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [15:0]          wr_data;
    logic                 running;
    logic                 ld_take;
    logic                 oor_acc;

    assign running = (state_q == RUN);
    assign ld_take = bus.ldValid && !running;

`ifdef MEMU_OOR_TRAP_EN
    assign oor_acc = running && (bus.addr[31:ADDR_BITS] != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.addr[31:ADDR_BITS];
    assign oor_acc = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        load_count_d = load_count_q;
        sel_d        = sel_q;
        oor_sel_d    = oor_sel_q;
        fault_d      = fault_q | oor_acc;
        wr_en        = 1'b0;
        wr_idx       = load_count_q[ADDR_BITS-1:0];
        wr_data      = {hi_q, bus.ldByte};
        case (state_q)
            LOAD_HI: begin
                if (ld_take) begin
                    hi_d = bus.ldByte;
                    if (bus.ldLast) begin
                        wr_en        = 1'b1;
                        wr_data      = {bus.ldByte, 8'h00};
                        load_count_d = load_count_q + 1'b1;
                        state_d      = RUN;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (ld_take) begin
                    wr_en        = 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    // Filling the last word forces RUN so loadCount saturates at DEPTH.
                    state_d      = (bus.ldLast || load_count_q == LAST_IDX) ? RUN : LOAD_HI;
                end
            end
            RUN: begin
                if (bus.memWrite) begin
                    wr_en   = !oor_acc;
                    wr_idx  = bus.addr[ADDR_BITS-1:0];
                    wr_data = bus.memOut;
                end else begin
                    sel_d     = bus.addr[ADDR_BITS-1:0];
                    oor_sel_d = oor_acc;
                end
            end
            default: state_d = LOAD_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= LOAD_HI;
            hi_q         <= 8'h00;
            load_count_q <= '0;
            sel_q        <= '0;
            oor_sel_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            load_count_q <= load_count_d;
            sel_q        <= sel_d;
            oor_sel_q    <= oor_sel_d;
            fault_q      <= fault_d;
        end
    end

    // RAM deliberately survives reset so a reload only rewrites what the new image covers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign bus.memDat  = (running && !oor_sel_q) ? mem[sel_q] : 16'h0000;
    assign bus.ldReady = !running;
    assign cpuRun      = running;
    assign loadCount   = load_count_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_memu.sv
// Directed bench for memu: a 256-word instance for load/run/trap scenarios and a 4-word one for the fill limit.
module tb_memu;
    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic       run_a, run_b, fault_a, fault_b;
    logic [8:0] lc_a;
    logic [2:0] lc_b;
    int         errors;
    int         checks;

    memu_if bus_a ();
    memu_if bus_b ();

    memu #(.ADDR_BITS(8)) u_a (
        .clk(clk), .rstN(rst_a), .bus(bus_a),
        .cpuRun(run_a), .loadCount(lc_a), .fault(fault_a)
    );

    memu #(.ADDR_BITS(2)) u_b (
        .clk(clk), .rstN(rst_b), .bus(bus_b),
        .cpuRun(run_b), .loadCount(lc_b), .fault(fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_a(input logic [7:0] b, input logic last);
        bus_a.ldValid = 1'b1;
        bus_a.ldByte  = b;
        bus_a.ldLast  = last;
        tick();
        bus_a.ldValid = 1'b0;
        bus_a.ldLast  = 1'b0;
    endtask

    task automatic ld_b(input logic [7:0] b, input logic last);
        bus_b.ldValid = 1'b1;
        bus_b.ldByte  = b;
        bus_b.ldLast  = last;
        tick();
        bus_b.ldValid = 1'b0;
        bus_b.ldLast  = 1'b0;
    endtask

    task automatic rd_a(input logic [31:0] a);
        bus_a.memWrite = 1'b0;
        bus_a.addr     = a;
        tick();
    endtask

    task automatic wr_a(input logic [31:0] a, input logic [15:0] d);
        bus_a.memWrite = 1'b1;
        bus_a.addr     = a;
        bus_a.memOut   = d;
        tick();
        bus_a.memWrite = 1'b0;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.addr = 32'h3; bus_a.memWrite = 1'b0; bus_a.memOut = 16'h0;
        bus_a.ldValid = 1'b0; bus_a.ldByte = 8'h0; bus_a.ldLast = 1'b0;
        bus_b.addr = 32'h0; bus_b.memWrite = 1'b0; bus_b.memOut = 16'h0;
        bus_b.ldValid = 1'b0; bus_b.ldByte = 8'h0; bus_b.ldLast = 1'b0;
        #2;
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL rst_cpuRun got %b exp 0", run_a); end
        checks++; if (bus_a.ldReady !== 1'b1) begin errors++; $display("FAIL rst_ldReady got %b exp 1", bus_a.ldReady); end
        checks++; if (lc_a !== 9'd0) begin errors++; $display("FAIL rst_loadCount got %0d exp 0", lc_a); end
        checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", fault_a); end
        checks++; if (bus_a.memDat !== 16'h0000) begin errors++; $display("FAIL rst_memDat got %h exp 0000", bus_a.memDat); end
        tick();
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_load_image();
        logic [7:0] img [6];
        img = '{8'h00, 8'h0A, 8'h80, 8'h07, 8'h66, 8'h38};
        for (int i = 0; i < 6; i++) ld_a(img[i], i == 5);
        checks++; if (lc_a !== 9'd3) begin errors++; $display("FAIL img_loadCount got %0d exp 3", lc_a); end
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL img_cpuRun got %b exp 1", run_a); end
        checks++; if (bus_a.ldReady !== 1'b0) begin errors++; $display("FAIL img_ldReady got %b exp 0", bus_a.ldReady); end
        rd_a(32'd0);
        checks++; if (bus_a.memDat !== 16'h000A) begin errors++; $display("FAIL img_rd0 got %h exp 000A", bus_a.memDat); end
        rd_a(32'd1);
        checks++; if (bus_a.memDat !== 16'h8007) begin errors++; $display("FAIL img_rd1 got %h exp 8007", bus_a.memDat); end
        rd_a(32'd2);
        checks++; if (bus_a.memDat !== 16'h6638) begin errors++; $display("FAIL img_rd2 got %h exp 6638", bus_a.memDat); end
    endtask

    task automatic test_write_read();
        wr_a(32'd5, 16'hBEEF);
        checks++; if (bus_a.memDat !== 16'h6638) begin errors++; $display("FAIL wr_hold_sel got %h exp 6638", bus_a.memDat); end
        rd_a(32'd5);
        checks++; if (bus_a.memDat !== 16'hBEEF) begin errors++; $display("FAIL wr_readback got %h exp BEEF", bus_a.memDat); end
        wr_a(32'd5, 16'h1111);
        checks++; if (bus_a.memDat !== 16'h1111) begin errors++; $display("FAIL wr_same_sel got %h exp 1111", bus_a.memDat); end
    endtask

    task automatic test_oor();
        wr_a(32'd4, 16'h4444);
        rd_a(32'h0000_0104);
`ifdef MEMU_OOR_TRAP_EN
        checks++; if (bus_a.memDat !== 16'h0000) begin errors++; $display("FAIL oor_rd got %h exp 0000", bus_a.memDat); end
        checks++; if (fault_a !== 1'b1) begin errors++; $display("FAIL oor_fault got %b exp 1", fault_a); end
`else
        checks++; if (bus_a.memDat !== 16'h4444) begin errors++; $display("FAIL oor_rd got %h exp 4444", bus_a.memDat); end
        checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL oor_fault got %b exp 0", fault_a); end
`endif
        wr_a(32'h0000_0104, 16'h9999);
        rd_a(32'd4);
`ifdef MEMU_OOR_TRAP_EN
        checks++; if (bus_a.memDat !== 16'h4444) begin errors++; $display("FAIL oor_wr_blocked got %h exp 4444", bus_a.memDat); end
        checks++; if (fault_a !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b exp 1", fault_a); end
`else
        checks++; if (bus_a.memDat !== 16'h9999) begin errors++; $display("FAIL oor_wr_wrap got %h exp 9999", bus_a.memDat); end
        checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL oor_sticky got %b exp 0", fault_a); end
`endif
    endtask

    task automatic test_short_load();
        reset_a();
        checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL sl_fault_clr got %b exp 0", fault_a); end
        // Core-side write attempted during load must be ignored.
        bus_a.memWrite = 1'b1;
        bus_a.addr     = 32'd2;
        bus_a.memOut   = 16'hFFFF;
        ld_a(8'h12, 1'b0);
        checks++; if (bus_a.memDat !== 16'h0000) begin errors++; $display("FAIL sl_memDat_idle got %h exp 0000", bus_a.memDat); end
        ld_a(8'h34, 1'b0);
        bus_a.memWrite = 1'b0;
        ld_a(8'h56, 1'b1);
        checks++; if (lc_a !== 9'd2) begin errors++; $display("FAIL sl_loadCount got %0d exp 2", lc_a); end
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL sl_cpuRun got %b exp 1", run_a); end
        rd_a(32'd0);
        checks++; if (bus_a.memDat !== 16'h1234) begin errors++; $display("FAIL sl_rd0 got %h exp 1234", bus_a.memDat); end
        rd_a(32'd1);
        checks++; if (bus_a.memDat !== 16'h5600) begin errors++; $display("FAIL sl_rd1 got %h exp 5600", bus_a.memDat); end
        rd_a(32'd2);
        checks++; if (bus_a.memDat !== 16'h6638) begin errors++; $display("FAIL sl_keep2 got %h exp 6638", bus_a.memDat); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 7; i++) ld_b(8'(i), 1'b0);
        checks++; if (run_b !== 1'b0) begin errors++; $display("FAIL fill_early_run got %b exp 0", run_b); end
        checks++; if (lc_b !== 3'd3) begin errors++; $display("FAIL fill_cnt7 got %0d exp 3", lc_b); end
        ld_b(8'h08, 1'b0);
        checks++; if (run_b !== 1'b1) begin errors++; $display("FAIL fill_run got %b exp 1", run_b); end
        checks++; if (lc_b !== 3'd4) begin errors++; $display("FAIL fill_cnt got %0d exp 4", lc_b); end
        ld_b(8'hEE, 1'b1);
        checks++; if (lc_b !== 3'd4) begin errors++; $display("FAIL fill_sat got %0d exp 4", lc_b); end
        checks++; if (bus_b.ldReady !== 1'b0) begin errors++; $display("FAIL fill_ldReady got %b exp 0", bus_b.ldReady); end
        bus_b.addr = 32'd3;
        tick();
        checks++; if (bus_b.memDat !== 16'h0708) begin errors++; $display("FAIL fill_rd3 got %h exp 0708", bus_b.memDat); end
        bus_b.addr = 32'd0;
        tick();
        checks++; if (bus_b.memDat !== 16'h0102) begin errors++; $display("FAIL fill_rd0 got %h exp 0102", bus_b.memDat); end
    endtask

    task automatic test_reset_mid_load();
        reset_a();
        ld_a(8'hAA, 1'b0);
        ld_a(8'hBB, 1'b0);
        ld_a(8'hCC, 1'b0);
        checks++; if (lc_a !== 9'd1) begin errors++; $display("FAIL mid_cnt got %0d exp 1", lc_a); end
        rst_a = 1'b0;
        #2;
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL mid_cpuRun got %b exp 0", run_a); end
        checks++; if (lc_a !== 9'd0) begin errors++; $display("FAIL mid_loadCount got %0d exp 0", lc_a); end
        checks++; if (bus_a.ldReady !== 1'b1) begin errors++; $display("FAIL mid_ldReady got %b exp 1", bus_a.ldReady); end
        tick();
        rst_a = 1'b1;
        ld_a(8'hC0, 1'b0);
        ld_a(8'hDE, 1'b1);
        checks++; if (lc_a !== 9'd1) begin errors++; $display("FAIL mid_reload_cnt got %0d exp 1", lc_a); end
        rd_a(32'd0);
        checks++; if (bus_a.memDat !== 16'hC0DE) begin errors++; $display("FAIL mid_reload_rd0 got %h exp C0DE", bus_a.memDat); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_load_image();
        test_write_read();
        test_oor();
        test_short_load();
        test_fill();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
